// File: rtl/chunked_alu_flags_if.sv
// Request/response bundle for chunked_alu_flags.
// STICKY_OVF_EN adds the ovf_clr / ovf_sticky pair.
interface chunked_alu_flags_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             zero;
  logic             cout;
`ifdef STICKY_OVF_EN
  logic             ovf_clr;
  logic             ovf_sticky;

  modport master (output start, a, b, op, ovf_clr,
                  input  busy, done, result, ovf, zero, cout, ovf_sticky);
  modport slave  (input  start, a, b, op, ovf_clr,
                  output busy, done, result, ovf, zero, cout, ovf_sticky);
`else
  modport master (output start, a, b, op,
                  input  busy, done, result, ovf, zero, cout);
  modport slave  (input  start, a, b, op,
                  output busy, done, result, ovf, zero, cout);
`endif
endinterface

// File: rtl/chunked_alu_flags.sv
// Multi-cycle add/sub/SLT/SLTU unit: adds CHUNK bits per cycle, low chunk first.
// Define STICKY_OVF_EN to add the accumulated-overflow flag (ovf_clr / ovf_sticky).
module chunked_alu_flags #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic           clk,
  input logic           reset,
  chunked_alu_flags_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = $clog2(NCH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_badParams
      $error("chunked_alu_flags: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_op;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_ovf;
  logic             r_zero;
  logic             r_cout;

  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK:0]   w_chunkAdd;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovI;
  logic             w_lt;
  logic [WIDTH-1:0] w_finalResult;
  logic             w_finalOvf;

  always_comb begin
    w_busy   = (r_state == RUN);
    w_done   = (r_state == DONE);
    w_accept = bus.start & ~w_busy;
    w_last   = w_busy & (r_idx == LAST_IDX);
    w_next   = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // w_sum is the full raw sum as it will look once the current chunk is stored,
  // so on the last RUN edge the flags see the complete word.
  always_comb begin
    w_aChunk   = r_a[int'(r_idx) * CHUNK +: CHUNK];
    w_bChunk   = r_b[int'(r_idx) * CHUNK +: CHUNK];
    w_chunkAdd = {1'b0, w_aChunk} + {1'b0, w_bChunk} + (CHUNK + 1)'(r_carry);
    w_sum      = r_sum;
    w_sum[int'(r_idx) * CHUNK +: CHUNK] = w_chunkAdd[CHUNK-1:0];
    w_ovI      = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    w_lt       = (r_op == 2'b10) ? (w_sum[WIDTH-1] ^ w_ovI) : ~w_chunkAdd[CHUNK];
    w_finalResult = r_op[1] ? {{(WIDTH-1){1'b0}}, w_lt} : w_sum;
    w_finalOvf    = r_op[1] ? 1'b0 : w_ovI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= (bus.op != 2'b00) ? ~bus.b : bus.b;
      r_carry <= (bus.op != 2'b00);
      r_op    <= bus.op;
      r_idx   <= '0;
    end else if (w_busy) begin
      r_sum   <= w_sum;
      r_carry <= w_chunkAdd[CHUNK];
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_result <= w_finalResult;
        r_ovf    <= w_finalOvf;
        r_zero   <= (w_finalResult == '0);
        r_cout   <= w_chunkAdd[CHUNK];
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;
  assign bus.cout   = r_cout;

`ifdef STICKY_OVF_EN
  logic r_ovfSticky;

  // A set in the done cycle wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_ovfSticky <= 1'b0;
    else if (w_done & r_ovf)  r_ovfSticky <= 1'b1;
    else if (bus.ovf_clr)     r_ovfSticky <= 1'b0;
  end

  assign bus.ovf_sticky = r_ovfSticky;
`endif

endmodule

// File: tb/tb_chunked_alu_flags.sv
// Scoreboard bench for chunked_alu_flags (WIDTH=32, CHUNK=8); directed vectors.
// Define STICKY_OVF_EN to also exercise the sticky overflow flag.
module tb_chunked_alu_flags;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 5;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        zero;
    logic        cout;
  } exp_t;

  logic clk;
  logic reset;
  chunked_alu_flags_if #(.WIDTH(WIDTH)) busIf();

  chunked_alu_flags #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf.slave)
  );

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cycleCnt = 0;
  int   acceptAt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [31:0] r, input logic o, input logic z, input logic c);
    exp_t e;
    e.result = r; e.ovf = o; e.zero = z; e.cout = c;
    return e;
  endfunction

  // Accept edge is recorded on the rising edge, before the DUT updates busy.
  always @(posedge clk) begin
    if (!reset && busIf.start && !busIf.busy) acceptAt = cycleCnt;
  end

  always @(negedge clk) begin
    if (!reset) begin
      cycleCnt++;
      if (busIf.done) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got done=1 expected no done at cycle %0d", cycleCnt);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("result",  busIf.result, e.result);
          checkOutput("ovf",     32'(busIf.ovf),  32'(e.ovf));
          checkOutput("zero",    32'(busIf.zero), 32'(e.zero));
          checkOutput("cout",    32'(busIf.cout), 32'(e.cout));
          checkOutput("latency", 32'(cycleCnt - acceptAt), 32'(LATENCY));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input exp_t e, input bit doPush);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busIf.busy && n < 100);
    if (busIf.busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL busyTimeout: got busy=1 expected 0 within 100 cycles");
    end
    busIf.start = 1'b1;
    busIf.op    = op;
    busIf.a     = a;
    busIf.b     = b;
    if (doPush) expQ.push_back(e);
    @(negedge clk);
    busIf.start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d pending expected 0", expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    busIf.start = 1'b0;
    busIf.op    = 2'b00;
    busIf.a     = '0;
    busIf.b     = '0;
`ifdef STICKY_OVF_EN
    busIf.ovf_clr = 1'b0;
`endif
    reset = 1'b1;
    idle(3);
    checkOutput("rstBusy",   32'(busIf.busy), 32'd0);
    checkOutput("rstDone",   32'(busIf.done), 32'd0);
    checkOutput("rstResult", busIf.result,    32'd0);
    checkOutput("rstOvf",    32'(busIf.ovf),  32'd0);
    checkOutput("rstZero",   32'(busIf.zero), 32'd0);
    checkOutput("rstCout",   32'(busIf.cout), 32'd0);
`ifdef STICKY_OVF_EN
    checkOutput("rstSticky", 32'(busIf.ovf_sticky), 32'd0);
`endif
    reset = 1'b0;
    idle(2);

    $display("[TB] back-to-back ADD/SUB");
    applyStimulus(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, mkExp(32'h8000_0000, 1'b1, 1'b0, 1'b0), 1'b1);
    applyStimulus(2'b01, 32'h0000_0005, 32'h0000_0005, mkExp(32'h0000_0000, 1'b0, 1'b1, 1'b1), 1'b1);
    applyStimulus(2'b01, 32'h0000_0003, 32'h0000_0005, mkExp(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), 1'b1);
    waitDrain();

    $display("[TB] compares");
    applyStimulus(2'b10, 32'h8000_0000, 32'h0000_0001, mkExp(32'h0000_0001, 1'b0, 1'b0, 1'b1), 1'b1);
    idle(2);
    applyStimulus(2'b11, 32'h8000_0000, 32'h0000_0001, mkExp(32'h0000_0000, 1'b0, 1'b1, 1'b1), 1'b1);
    applyStimulus(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, mkExp(32'h0000_0000, 1'b0, 1'b1, 1'b0), 1'b1);
    applyStimulus(2'b11, 32'h0000_0001, 32'h8000_0000, mkExp(32'h0000_0001, 1'b0, 1'b0, 1'b0), 1'b1);
    waitDrain();

    $display("[TB] carry chain and ignored start");
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, mkExp(32'h0000_0000, 1'b0, 1'b1, 1'b1), 1'b1);
    waitDrain();
    applyStimulus(2'b00, 32'h1234_5678, 32'h1111_1111, mkExp(32'h2345_6789, 1'b0, 1'b0, 1'b0), 1'b1);
    busIf.start = 1'b1;
    busIf.op    = 2'b01;
    busIf.a     = 32'hDEAD_BEEF;
    busIf.b     = 32'h0000_0001;
    @(negedge clk);
    busIf.start = 1'b0;
    waitDrain();
    idle(6);
    applyStimulus(2'b01, 32'h8000_0000, 32'h0000_0001, mkExp(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1), 1'b1);
    waitDrain();

`ifdef STICKY_OVF_EN
    $display("[TB] sticky overflow");
    checkOutput("stickySet", 32'(busIf.ovf_sticky), 32'd1);
    applyStimulus(2'b00, 32'h0000_0001, 32'h0000_0002, mkExp(32'h0000_0003, 1'b0, 1'b0, 1'b0), 1'b1);
    waitDrain();
    checkOutput("stickyHold", 32'(busIf.ovf_sticky), 32'd1);
    busIf.ovf_clr = 1'b1;
    @(negedge clk);
    busIf.ovf_clr = 1'b0;
    checkOutput("stickyClr", 32'(busIf.ovf_sticky), 32'd0);
    busIf.ovf_clr = 1'b1;
    applyStimulus(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, mkExp(32'h8000_0000, 1'b1, 1'b0, 1'b0), 1'b1);
    waitDrain();
    checkOutput("stickySetBeatsClr", 32'(busIf.ovf_sticky), 32'd1);
    @(negedge clk);
    checkOutput("stickyClrAfter", 32'(busIf.ovf_sticky), 32'd0);
    busIf.ovf_clr = 1'b0;
    applyStimulus(2'b01, 32'h8000_0000, 32'h0000_0001, mkExp(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1), 1'b1);
    waitDrain();
`endif

    $display("[TB] reset mid-run");
    applyStimulus(2'b00, 32'h0F0F_0F0F, 32'h0101_0101, mkExp(32'h0, 1'b0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abortBusy",   32'(busIf.busy), 32'd0);
    checkOutput("abortDone",   32'(busIf.done), 32'd0);
    checkOutput("abortResult", busIf.result,    32'd0);
    checkOutput("abortOvf",    32'(busIf.ovf),  32'd0);
    checkOutput("abortCout",   32'(busIf.cout), 32'd0);
`ifdef STICKY_OVF_EN
    checkOutput("abortSticky", 32'(busIf.ovf_sticky), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    idle(10);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
